// File: rtl/ps2_scancode_sequencer.sv
// PS/2 scancode sequencer: pops bytes from the receiver into a small FIFO and
// folds E0/F0 prefixes into single key events with modifier and error tracking.
module ps2_scancode_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ps2_data,
  input  logic              ps2_ready,
  input  logic              ps2_overflow,
  output logic              ps2_nextdata_n,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [7:0]        evt_code,
  output logic              evt_ext,
  output logic              evt_break,
  output logic              shift_held,
  output logic              ctrl_held,
  output logic [ADDR_W:0]   fifo_count,
  output logic              err_flag
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} parse_state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(FIFO_DEPTH);

  logic [7:0]        fifo_mem [0:FIFO_DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              cooldown;

  parse_state_t      state;
  parse_state_t      state_next;

  logic              fifo_full;
  logic              fifo_empty;
  logic              do_pop;
  logic              slot_free;
  logic              do_read;
  logic [7:0]        rd_byte;
  logic              emit;
  logic              emit_ext;
  logic              emit_brk;
  logic              malformed;
  logic              is_prefix;

  assign fifo_full  = (count == DEPTH_L);
  assign fifo_empty = (count == '0);
  // The cooldown covers the cycle in which the receiver has not yet seen our strobe.
  assign do_pop     = ps2_ready && !fifo_full && !cooldown;
  assign slot_free  = !evt_valid || evt_ready;
  assign do_read    = !fifo_empty && slot_free;
  assign rd_byte    = fifo_mem[rd_ptr];
  assign is_prefix  = (rd_byte == 8'hE0) || (rd_byte == 8'hF0);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (do_pop) begin
      fifo_mem[wr_ptr] <= ps2_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      cooldown       <= 1'b0;
      ps2_nextdata_n <= 1'b1;
    end else begin
      cooldown       <= do_pop;
      ps2_nextdata_n <= !do_pop;
      if (do_pop) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_pop, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    malformed  = 1'b0;
    if (do_read) begin
      case (state)
        IDLE: begin
          if (rd_byte == 8'hE0) begin
            state_next = EXT;
          end else if (rd_byte == 8'hF0) begin
            state_next = BRK;
          end else if ((rd_byte != 8'hAA) && (rd_byte != 8'hFA)) begin
            emit = 1'b1;
          end
        end
        EXT: begin
          if (rd_byte == 8'hF0) begin
            state_next = EXT_BRK;
          end else if (rd_byte != 8'hE0) begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            state_next = IDLE;
          end
        end
        BRK: begin
          state_next = IDLE;
          if (is_prefix) begin
            malformed = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
          end
        end
        EXT_BRK: begin
          state_next = IDLE;
          if (is_prefix) begin
            malformed = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A byte is only read when the slot is free, so an emit may always overwrite.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid  <= 1'b0;
      evt_code   <= 8'h00;
      evt_ext    <= 1'b0;
      evt_break  <= 1'b0;
      shift_held <= 1'b0;
      ctrl_held  <= 1'b0;
    end else begin
      if (emit) begin
        evt_valid <= 1'b1;
        evt_code  <= rd_byte;
        evt_ext   <= emit_ext;
        evt_break <= emit_brk;
        if ((rd_byte == 8'h12) || (rd_byte == 8'h59)) begin
          shift_held <= !emit_brk;
        end
        if (rd_byte == 8'h14) begin
          ctrl_held <= !emit_brk;
        end
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_flag <= 1'b0;
    end else if (malformed || ps2_overflow) begin
      err_flag <= 1'b1;
    end
  end

endmodule

// File: doc/ps2_scancode_sequencer.md
Name: ps2_scancode_sequencer

Overview:
- Sits between the PS/2 byte receiver and keyboard display/decode logic.
- Pops raw bytes from the receiver with a one-cycle active-low strobe and buffers them in a small FIFO.
- Parses make, break (F0) and extended (E0) sequences into single key events on a valid/ready handshake.
- Tracks Shift/Ctrl held state and reports FIFO depth and sticky error status.

Parameters:
- FIFO_DEPTH, 8, byte FIFO entries; power of two, minimum 2.
- ADDR_W, 3, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-low; all state cleared while rst=0.
- ps2_data  in  8  byte presented by receiver.
- ps2_ready  in  1  receiver holds an unread byte.
- ps2_overflow  in  1  receiver lost a byte.
- ps2_nextdata_n  out  1  active-low pop strobe to receiver.
- evt_valid  out  1  key event available.
- evt_ready  in  1  consumer accepts event.
- evt_code  out  8  scancode, without E0/F0 prefixes.
- evt_ext  out  1  event was E0-prefixed.
- evt_break  out  1  1 = release, 0 = press.
- shift_held  out  1  left (12) or right (59) Shift is down.
- ctrl_held  out  1  Ctrl (14, or E0 14) is down.
- fifo_count  out  ADDR_W+1  occupancy, 0..FIFO_DEPTH.
- err_flag  out  1  sticky error.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - ps2_nextdata_n=1; evt_valid=0; evt_code=0; evt_ext=0; evt_break=0.
  - shift_held=0; ctrl_held=0; fifo_count=0; err_flag=0.
  - FIFO pointers 0; parser state IDLE; pop cooldown clear.
  - Reset mid-sequence discards any partial prefix and all FIFO contents.
- Pop/intake:
  - Pop condition: ps2_ready=1, FIFO not full, and cooldown clear.
  - On a pop: ps2_data is written into the FIFO and ps2_nextdata_n is driven low for exactly one cycle (registered).
  - The cooldown is set for the following cycle, so no second pop occurs before the receiver updates ps2_ready.
  - Back-to-back pops are therefore at most one per 2 cycles.
  - FIFO full with ps2_ready=1: no pop and no error; the receiver holds the byte.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Simultaneous write and read in one cycle: fifo_count unchanged.
  - fifo_count updates the cycle after the write or read.
- Parser read condition: FIFO not empty and output slot free, where slot free means (evt_valid=0 or evt_ready=1). At most one byte is read per cycle.
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte X -> emit (X, ext=0, brk=0), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; X -> emit (X, 1, 0) -> IDLE.
  - BRK: X -> emit (X, 0, 1) -> IDLE; E0 or F0 -> set err_flag, go to IDLE, nothing emitted.
  - EXT_BRK: X -> emit (X, 1, 1) -> IDLE; E0 or F0 -> set err_flag, go to IDLE.
  - Byte AA (self-test pass) or FA (ack) in IDLE: consumed silently, no event.
- Event register:
  - Emit loads evt_code, evt_ext and evt_break and sets evt_valid on the next clock edge. Latency is 1 cycle from the FIFO read.
  - Event fields are held stable while evt_valid=1 and evt_ready=0.
  - evt_valid=1 and evt_ready=1 with no new emit: evt_valid clears next cycle.
  - evt_valid=1 and evt_ready=1 with a new emit in the same cycle: new event loaded, evt_valid stays 1 (full throughput).
- Modifier tracking: shift_held and ctrl_held update in the same cycle the event is loaded.
  - Make of 12 or 59 sets shift_held; break of either clears it.
  - Ctrl: make of code 14 (ext=0 or ext=1) sets ctrl_held; break of code 14 clears it.
  - Typematic repeat makes keep the flag at 1.
- err_flag:
  - Set by a malformed sequence or by ps2_overflow=1 on any cycle.
  - Cleared only by reset.

Test Plan:
- Reset then feed 1C, F0, 1C (each: ps2_ready held until pop), evt_ready=1 -> two events: (1C, 0, 0) then (1C, 0, 1); ps2_nextdata_n low exactly 3 single cycles; fifo_count returns to 0.
- Feed E0, 75, E0, F0, 75 -> events (75, 1, 0) and (75, 1, 1); no event for prefixes; err_flag=0.
- Feed 12, 1C, F0, 12 -> shift_held=1 when the 12 make event loads, still 1 at 1C event, 0 when the 12 break event loads.
- Hold evt_ready=0, stream 9 non-prefix bytes (FIFO_DEPTH=8) -> 1 event held stable plus fifo_count=8; 10th byte not popped (ps2_nextdata_n stays 1). Release evt_ready=1 -> all remaining events drain in order, one per cycle.
- Feed F0, F0 -> err_flag=1, parser in IDLE; next byte 2D yields (2D, 0, 0). Pulse ps2_overflow -> err_flag stays 1.
- Assert rst=0 asynchronously after an E0 with 3 bytes queued -> all outputs at reset values immediately; after release, byte 1C yields (1C, 0, 0).
